// File: rtl/counter.sv
// counter: free-running WIDTH-bit up-counter.
// Asynchronous active-low clear, synchronous active-high count enable,
// and modulo-2^WIDTH wrap. The output is driven straight from the state
// register, so no input reaches `value` through combinational logic.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next count: add one when enabled; the adder wraps naturally at WIDTH bits.
  always_comb begin
    value_d = value_q;
    if (enable) value_d = value_q + WIDTH'(1);
  end

  // Count register; a low reset clears it at once and holds it at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed and randomized checks of counter against a
// reference that counts enabled edges since the last reset.
module tb_counter;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] value;

  int total = 0;
  int bad   = 0;

  // Reference: number of enabled edges since reset, reduced mod 2^W on read.
  int unsigned edges = 0;
  bit          valid = 0;

  counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .value  (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (%b) expected %0d at %0t", name, got, got, exp, $time);
    end
  endtask

  // Reference model: cleared by reset, counts edges that see enable high.
  always @(posedge clk or negedge reset) begin
    if (reset === 1'b0) begin
      edges = 0;
      valid = 1;
    end else if (valid && enable === 1'b1) begin
      edges = edges + 1;
    end
  end

  // Continuous comparison, mid-cycle, once a reset has been seen.
  always @(negedge clk) begin
    if (valid) chk("model", value, W'(edges % (1 << W)));
  end

  // Advance to 3 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;

    // Reset from unknown, then release with enable low.
    tick(); tick();
    chk("rst_unknown", value, 8'd0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_release_hold", value, 8'd0);
    end

    // Basic count through full range and wrap.
    enable = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 255)      chk("reach_max", value, 8'd255);
      else if (i == 256) chk("wrap_zero", value, 8'd0);
      else if (i == 257) chk("wrap_one", value, 8'd1);
      else               chk("count", value, W'(i % 256));
    end

    // Asynchronous clear between edges, then enable hold at 10.
    reset = 1'b0;
    #1 chk("async_clr", value, 8'd0);
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("count_to_10", value, W'(i));
    end
    enable = 1'b0;
    repeat (5) begin
      tick();
      chk("enable_hold", value, 8'd10);
    end
    enable = 1'b1;
    tick();
    chk("reenable", value, 8'd11);

    // Count to 100, then reset mid-count and resume.
    for (int i = 12; i <= 100; i++) begin
      tick();
      chk("count_to_100", value, W'(i));
    end
    reset = 1'b0;
    #1 chk("midcount_clr", value, 8'd0);
    tick();
    chk("midcount_held", value, 8'd0);
    reset = 1'b1;
    tick();
    chk("resume_1", value, 8'd1);
    tick();
    chk("resume_2", value, 8'd2);

    // Reset dominates enable.
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) begin
      tick();
      chk("rst_dominance", value, 8'd0);
    end
    reset = 1'b1;

    // Randomized enable with occasional reset pulses.
    repeat (3000) begin
      tick();
      enable = 1'($urandom % 2);
      reset  = ($urandom_range(0, 99) != 0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
